// File: rtl/lp_arith_pkg.sv
// lp_arith_pkg: shared widths, operand types and divider states for the low-power arithmetic path
package lp_arith_pkg;
  localparam int W = 8;
  localparam int ITER = 2 * W;
  typedef logic [W-1:0] operand_t;
  typedef logic [2*W-1:0] product_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
endpackage

// File: rtl/lp_div_step.sv
// lp_div_step: one combinational restoring-division step
module lp_div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   i_pr,
  input  logic         i_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_pr,
  output logic         o_q
);
  logic [W:0] w_sh;
  assign w_sh = {i_pr[W-1:0], i_bit};
  assign o_q  = w_sh >= {1'b0, i_divisor};
  assign o_pr = o_q ? w_sh - {1'b0, i_divisor} : w_sh;
endmodule

// File: rtl/low_power_divider.sv
// low_power_divider: sequential restoring divider, one quotient bit per enabled clock
module low_power_divider
  import lp_arith_pkg::*;
#(
  parameter int W = lp_arith_pkg::W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           q_ovf
);
  localparam int CW = $clog2(2 * W);
  div_state_t     r_state, w_next;
  logic [2*W-1:0] r_sreg, r_q, w_qn;
  logic [W-1:0]   r_div, r_r;
  logic [W:0]     r_pr, w_pr;
  logic [CW-1:0]  r_cnt;
  logic           r_dz, r_ovf, w_qb, w_acc, w_step, w_last;
  lp_div_step #(.W(W)) u_step (
    .i_pr(r_pr), .i_bit(r_sreg[2*W-1]), .i_divisor(r_div), .o_pr(w_pr), .o_q(w_qb)
  );
  assign w_acc  = start & enable & (r_state == IDLE);
  assign w_step = enable & (r_state == RUN);
  assign w_last = w_step & (r_cnt == '0);
  assign w_qn   = {r_sreg[2*W-2:0], w_qb};
  // DONE always falls back to IDLE so the done pulse cannot stick under enable=0
  always_comb begin
    w_next = r_state;
    w_next = (r_state == DONE) ? IDLE
           : w_acc  ? ((divisor == '0) ? DONE : RUN)
           : w_last ? DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_div   <= '0;
      r_pr    <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_sreg <= dividend;
        r_div  <= divisor;
        r_pr   <= '0;
        r_cnt  <= CW'(2 * W - 1);
        if (divisor == '0) begin
          r_q   <= '1;
          r_r   <= dividend[W-1:0];
          r_dz  <= 1'b1;
          r_ovf <= 1'b1;
        end
      end
      if (w_step) begin
        r_sreg <= w_qn;
        r_pr   <= w_pr;
        r_cnt  <= r_cnt - 1'b1;
      end
      if (w_last) begin
        r_q   <= w_qn;
        r_r   <= w_pr[W-1:0];
        r_dz  <= 1'b0;
        r_ovf <= |w_qn[2*W-1:W];
      end
    end
  end
  assign busy      = r_state == RUN;
  assign done      = r_state == DONE;
  assign quotient  = r_q;
  assign remainder = r_r;
  assign div_zero  = r_dz;
  assign q_ovf     = r_ovf;
endmodule

// File: tb/tb_low_power_divider.sv
// tb_low_power_divider: table-driven and sequence checks for low_power_divider
module tb_low_power_divider;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, start = 1'b0;
  logic [15:0] dividend = '0, quotient;
  logic [7:0]  divisor = '0, remainder;
  logic        busy, done, div_zero, q_ovf;
  int          total = 0, bad = 0;
  low_power_divider dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero), .q_ovf(q_ovf)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    int          lat;
  } vec_t;
  vec_t vt[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic run(input logic [15:0] dd, input logic [7:0] dv, input bit tog,
                     output int lat, output bit saw_busy, output bit gap);
    dividend = dd; divisor = dv; start = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
    lat = 0; saw_busy = 0; gap = 0;
    while (!done && lat < 100) begin
      if (busy) saw_busy = 1; else gap = 1;
      enable = tog ? (lat % 2 == 0) : 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    enable = 1'b1;
    if (lat >= 100) chk("timeout", 32'(lat), 32'd0);
  endtask
  initial begin
    int lat;
    bit sb, gp;
    vt[0] = '{16'h00D2, 8'h0A, 16'h0015, 8'h00, 1'b0, 1'b0, 16};
    vt[1] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 1'b1, 16};
    vt[2] = '{16'h1234, 8'hFF, 16'h0012, 8'h46, 1'b0, 1'b0, 16};
    vt[3] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1'b1, 0};
    vt[4] = '{16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0, 1'b0, 16};
    vt[5] = '{16'h0006, 8'h07, 16'h0000, 8'h06, 1'b0, 1'b0, 16};
    vt[6] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 1'b1, 16};
    vt[7] = '{16'hFE01, 8'hFF, 16'h00FF, 8'h00, 1'b0, 1'b0, 16};
    vt[8] = '{16'hFFFE, 8'hFF, 16'h0100, 8'hFE, 1'b0, 1'b1, 16};
    vt[9] = '{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 1'b0, 16};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outs", {busy, done, div_zero, q_ovf, quotient, remainder}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      run(vt[i].dd, vt[i].dv, 1'b0, lat, sb, gp);
      chk($sformatf("v%0d_res", i), {6'd0, div_zero, q_ovf, quotient, remainder},
          {6'd0, vt[i].dz, vt[i].ovf, vt[i].q, vt[i].r});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_busy", i), {sb, gp, busy}, {vt[i].dv != 0, 1'b0, 1'b0});
      // start offered while DONE is showing must be dropped
      start = 1'b1; divisor = 8'h05;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("v%0d_post", i), {done, busy}, 2'b00);
      chk($sformatf("v%0d_hold", i), quotient, vt[i].q);
    end
    run(16'h0018, 8'h03, 1'b1, lat, sb, gp);
    chk("tog_res", {quotient, remainder}, {16'h0008, 8'h00});
    chk("tog_lat", 32'(lat), 32'd31);
    chk("tog_busy", {sb, gp}, 2'b10);
    @(posedge clk); #1;
    dividend = 16'h00D2; divisor = 8'h0A; start = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; enable = 1'b1;
    chk("start_en0", {busy, done}, 2'b00);
    dividend = 16'h00D2; divisor = 8'h0A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst", {busy, done, div_zero, q_ovf, quotient, remainder}, 32'd0);
    run(16'h00D2, 8'h0A, 1'b0, lat, sb, gp);
    chk("after_rst", {quotient, remainder, 8'(lat)}, {16'h0015, 8'h00, 8'd16});
    @(posedge clk); #1;
    dividend = 16'h0064; divisor = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5) begin dividend = 16'hFFFF; divisor = 8'h01; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("ign_start", {quotient, remainder, 8'(lat)}, {16'h000E, 8'h02, 8'd16});
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] dd;
      logic [7:0]  dv;
      dd = 16'($urandom);
      dv = 8'($urandom_range(1, 255));
      run(dd, dv, 1'b0, lat, sb, gp);
      chk($sformatf("rnd%0d", i),
          {quotient, remainder, 7'd0, q_ovf, 32'(quotient) * dv + remainder == dd},
          {dd / dv, 8'(dd % dv), 7'd0, (dd / dv) > 16'h00FF, 1'b1});
      @(posedge clk); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
